// File: rtl/wb_stage.sv
// MEM/WB pipeline register with load alignment/extension, HI/LO ownership and retire counter.
// Optional debug trace outputs are enabled by defining DEBUG_TRACE_EN.
module wb_stage #(
  parameter int          CNT_WIDTH  = 32,
  parameter logic [63:0] HILO_RESET = 64'h0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 mem_valid,
  input  logic                 MemtoRegIn,
  input  logic                 RegWriteIn,
  input  logic                 HI_LO_weIn,
  input  logic [63:0]          HI_LO_dataIn,
  input  logic [31:0]          ALUoutIn,
  input  logic [31:0]          Memdata,
  input  logic [2:0]           MemReadTypeIn,
  input  logic [6:0]           WriteRegisterIn,
  input  logic [31:0]          PCin,
  input  logic [3:0]           exception_in,
  input  logic                 is_ds_in,
`ifdef DEBUG_TRACE_EN
  output logic [31:0]          debug_wb_pc,
  output logic [3:0]           debug_wb_rf_wen,
  output logic [4:0]           debug_wb_rf_wnum,
  output logic [31:0]          debug_wb_rf_wdata,
`endif
  output logic                 reg_we,
  output logic [6:0]           reg_waddr,
  output logic [31:0]          reg_wdata,
  output logic [31:0]          hi,
  output logic [31:0]          lo,
  output logic                 wb_valid,
  output logic [31:0]          wb_pc,
  output logic                 wb_is_ds,
  output logic [3:0]           wb_exception,
  output logic [CNT_WIDTH-1:0] retired
);

  typedef struct packed {
    logic        valid;
    logic        mem_to_reg;
    logic        reg_write;
    logic        hilo_we;
    logic [63:0] hilo_data;
    logic [31:0] alu_out;
    logic [31:0] mem_data;
    logic [2:0]  read_type;
    logic [6:0]  waddr;
    logic [31:0] pc;
    logic [3:0]  exception;
    logic        is_ds;
  } wb_entry_t;

  wb_entry_t            entry_q, entry_d;
  logic [63:0]          hilo_q;
  logic [CNT_WIDTH-1:0] retired_q, retired_d;
  logic                 commit;
  logic                 new_real;
  logic [7:0]           ld_byte;
  logic [15:0]          ld_half;
  logic [31:0]          ld_data;

  always_comb begin
    entry_d = entry_q;
    if (flush) begin
      entry_d = '0;
    end else if (!stall) begin
      entry_d.valid      = mem_valid;
      entry_d.mem_to_reg = MemtoRegIn;
      entry_d.reg_write  = RegWriteIn;
      entry_d.hilo_we    = HI_LO_weIn;
      entry_d.hilo_data  = HI_LO_dataIn;
      entry_d.alu_out    = ALUoutIn;
      entry_d.mem_data   = Memdata;
      entry_d.read_type  = MemReadTypeIn;
      entry_d.waddr      = WriteRegisterIn;
      entry_d.pc         = PCin;
      entry_d.exception  = exception_in;
      entry_d.is_ds      = is_ds_in;
    end
  end

  // Excepting instructions still enter WB, so they are counted here.
  assign new_real  = mem_valid & ~flush & ~stall;
  assign retired_d = retired_q + CNT_WIDTH'(new_real);

  always_ff @(posedge clk) begin
    if (rst) begin
      entry_q   <= '0;
      retired_q <= '0;
      hilo_q    <= HILO_RESET;
    end else begin
      entry_q   <= entry_d;
      retired_q <= retired_d;
      if (commit && entry_q.hilo_we) begin
        hilo_q <= entry_q.hilo_data;
      end
    end
  end

  assign commit = entry_q.valid & (entry_q.exception == 4'h0);

  always_comb begin
    ld_byte = 8'h00;
    case (entry_q.alu_out[1:0])
      2'b00:   ld_byte = entry_q.mem_data[7:0];
      2'b01:   ld_byte = entry_q.mem_data[15:8];
      2'b10:   ld_byte = entry_q.mem_data[23:16];
      default: ld_byte = entry_q.mem_data[31:24];
    endcase
    ld_half = entry_q.alu_out[1] ? entry_q.mem_data[31:16] : entry_q.mem_data[15:0];
    case (entry_q.read_type[1:0])
      2'b00:   ld_data = entry_q.read_type[2] ? {24'h0, ld_byte}
                                              : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = entry_q.read_type[2] ? {16'h0, ld_half}
                                              : {{16{ld_half[15]}}, ld_half};
      default: ld_data = entry_q.mem_data;
    endcase
  end

  assign reg_we       = commit & entry_q.reg_write & (entry_q.waddr != 7'd0);
  assign reg_waddr    = entry_q.waddr;
  assign reg_wdata    = entry_q.mem_to_reg ? ld_data : entry_q.alu_out;
  assign hi           = hilo_q[63:32];
  assign lo           = hilo_q[31:0];
  assign wb_valid     = entry_q.valid;
  assign wb_pc        = entry_q.pc;
  assign wb_is_ds     = entry_q.is_ds;
  assign wb_exception = entry_q.exception;
  assign retired      = retired_q;

`ifdef DEBUG_TRACE_EN
  // Masking with stall reports a held entry only on its final WB cycle.
  assign debug_wb_pc       = entry_q.pc;
  assign debug_wb_rf_wen   = {4{reg_we}} & ~{4{stall}};
  assign debug_wb_rf_wnum  = reg_waddr[4:0];
  assign debug_wb_rf_wdata = reg_wdata;
`endif

endmodule
